// File: rtl/spi_responder_pkg.sv
// Shared types for the SPI responder: frame state encoding and counter sizing.
package spi_responder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      COMPLETE
   } state_t;

   function automatic int counter_width(input int max_length);
      return $clog2(max_length + 1);
   endfunction

endpackage

// File: rtl/axi_stream.sv
// Minimal AXI-stream bundle used for the responder's RX and TX word paths.
interface axi_stream #(
   parameter int WIDTH = 32
) ();
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;
   logic             last;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/spi_input_synchronizer.sv
// Synchroniser chain for one asynchronous SPI pin plus a history register for edge detection.
module spi_input_synchronizer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic pin,
   output logic level,
   output logic changed
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   held;

   always_ff @(posedge clock) begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      held  <= chain[SYNC_STAGES-1];
   end

   // level is the previous synchronised value; level ^ changed is the newest one
   assign level   = held;
   assign changed = chain[SYNC_STAGES-1] ^ held;

endmodule

// File: rtl/spi_responder.sv
// SPI slave engine: deserialises MOSI frames into an AXI-stream word and serialises
// a word from the TX stream onto MISO, all oversampled on the system clock.
module spi_responder
   import spi_responder_pkg::*;
#(
   parameter int MAX_LENGTH  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       sclk,
   input  logic       ss,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_enable,
   input  logic [5:0] transfer_length,
   input  logic       clock_polarity,
   input  logic       latching_edge,
   input  logic       ss_polarity,
   output logic       busy,
   output logic       overrun,
   output logic       underrun,
   output logic       aborted,
   axi_stream.master  received_data,
   axi_stream.slave   transmit_data
);

   localparam int CW = counter_width(MAX_LENGTH);

   function automatic logic [CW-1:0] decode_length(input logic [5:0] value);
      if (value == 6'd0 || int'(value) > MAX_LENGTH) return CW'(MAX_LENGTH);
      return CW'(value);
   endfunction

   state_t                state, next_state;
   logic                  sclk_level, sclk_changed, ss_level, ss_changed, mosi_level, mosi_changed;
   logic                  sclk_now, ss_now, mosi_now;
   logic                  ss_assert_edge, ss_asserted, sample_edge, shift_edge;
   logic                  start, sample, shift, finish, abort;
   logic [CW-1:0]         length_in, frame_length, bit_count;
   logic                  frame_cpol, frame_edge, frame_ss_polarity;
   logic [MAX_LENGTH-1:0] tx_shift, rx_shift, rx_data;
   logic                  rx_valid, tx_ready;

   spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) sclk_sync (
      .clock(clock), .pin(sclk), .level(sclk_level), .changed(sclk_changed));
   spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) ss_sync (
      .clock(clock), .pin(ss), .level(ss_level), .changed(ss_changed));
   spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) mosi_sync (
      .clock(clock), .pin(mosi), .level(mosi_level), .changed(mosi_changed));

   assign sclk_now       = sclk_level ^ sclk_changed ^ frame_cpol;
   assign ss_now         = ss_level ^ ss_changed;
   assign mosi_now       = mosi_level ^ mosi_changed;
   assign ss_assert_edge = ss_changed && (ss_now == ss_polarity);
   assign ss_asserted    = (ss_now == frame_ss_polarity);
   assign sample_edge    = sclk_changed && (sclk_now ^ frame_edge);
   assign shift_edge     = sclk_changed && !(sclk_now ^ frame_edge);
   assign length_in      = decode_length(transfer_length);

   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      start      = 1'b0;
      sample     = 1'b0;
      shift      = 1'b0;
      finish     = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (ss_assert_edge) begin
               start      = 1'b1;
               next_state = ACTIVE;
            end
         end
         ACTIVE: begin
            // a fully received frame completes even if ss drops in the same cycle
            if (bit_count == frame_length) begin
               next_state = COMPLETE;
            end else if (!ss_asserted) begin
               abort      = 1'b1;
               next_state = IDLE;
            end else begin
               sample = sample_edge;
               shift  = shift_edge && (bit_count != '0);
            end
         end
         COMPLETE: begin
            finish     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (start) begin
         frame_length      <= length_in;
         frame_cpol        <= clock_polarity;
         frame_edge        <= latching_edge;
         frame_ss_polarity <= ss_polarity;
         // left-align the TX word so the first bit out is always the register MSB
         tx_shift  <= transmit_data.valid ?
                      (transmit_data.data << (MAX_LENGTH - int'(length_in))) : '0;
         rx_shift  <= '0;
         bit_count <= '0;
      end else begin
         if (sample) begin
            rx_shift  <= {rx_shift[MAX_LENGTH-2:0], mosi_now};
            bit_count <= bit_count + CW'(1);
         end
         if (shift) tx_shift <= {tx_shift[MAX_LENGTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         miso     <= 1'b0;
         overrun  <= 1'b0;
         underrun <= 1'b0;
         aborted  <= 1'b0;
         tx_ready <= 1'b0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         miso     <= (state == ACTIVE) && tx_shift[MAX_LENGTH-1];
         underrun <= start && !transmit_data.valid;
         tx_ready <= start && transmit_data.valid;
         aborted  <= abort;
         overrun  <= finish && rx_valid;
         if (finish && !rx_valid) begin
            rx_valid <= 1'b1;
            rx_data  <= rx_shift;
         end else if (rx_valid && received_data.ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign busy                = (state == ACTIVE);
   assign miso_enable         = (state == ACTIVE);
   assign transmit_data.ready = tx_ready;
   assign received_data.data  = rx_data;
   assign received_data.valid = rx_valid;
   assign received_data.last  = 1'b1;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: an SPI master model drives frames and a word-level model predicts results.
module tb_spi_responder;
   import spi_responder_pkg::*;

   localparam int HALF = 8;
   localparam int SYNC = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       sclk = 1'b0;
   logic       ss = 1'b1;
   logic       mosi = 1'b0;
   logic       miso, miso_enable, busy, overrun, underrun, aborted;
   logic [5:0] transfer_length = 6'd8;
   logic       clock_polarity = 1'b0;
   logic       latching_edge = 1'b0;
   logic       ss_polarity = 1'b0;

   axi_stream #(.WIDTH(32)) rx_bus ();
   axi_stream #(.WIDTH(32)) tx_bus ();

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int overrun_seen = 0, underrun_seen = 0, aborted_seen = 0, ready_seen = 0;
   int valid_rise_cycle = -1;
   int last_sample_cycle = -1;
   int rx_read = 0;
   logic prev_valid = 1'b0;
   logic [31:0] rx_q[$];

   spi_responder #(.MAX_LENGTH(32), .SYNC_STAGES(SYNC)) dut (
      .clock(clock), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
      .miso(miso), .miso_enable(miso_enable), .transfer_length(transfer_length),
      .clock_polarity(clock_polarity), .latching_edge(latching_edge),
      .ss_polarity(ss_polarity), .busy(busy), .overrun(overrun),
      .underrun(underrun), .aborted(aborted),
      .received_data(rx_bus), .transmit_data(tx_bus));

   always #5 clock = ~clock;

   always @(posedge clock) cycle <= cycle + 1;

   always @(negedge clock) begin
      if (overrun)      overrun_seen  <= overrun_seen + 1;
      if (underrun)     underrun_seen <= underrun_seen + 1;
      if (aborted)      aborted_seen  <= aborted_seen + 1;
      if (tx_bus.ready) ready_seen    <= ready_seen + 1;
      if (rx_bus.valid && rx_bus.ready) rx_q.push_back(rx_bus.data);
      if (rx_bus.valid && !prev_valid) valid_rise_cycle <= cycle;
      prev_valid <= rx_bus.valid;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] low_bits(input logic [31:0] w, input int n);
      if (n >= 32) return w;
      return w & ((32'h1 << n) - 32'h1);
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic configure(input logic cpol, input logic edge_sel, input logic ss_pol,
                            input logic [5:0] len_field);
      clock_polarity  = cpol;
      latching_edge   = edge_sel;
      ss_polarity     = ss_pol;
      transfer_length = len_field;
      sclk = cpol;
      ss   = ~ss_pol;
      mosi = 1'b0;
      cycles(8);
   endtask

   // SPI master: drives `bits` bits of `send` MSB first and captures MISO before each sample edge
   task automatic run_frame(input logic [31:0] send, input int len, input int bits,
                            input bit release_ss, output logic [31:0] got);
      got = '0;
      ss = ss_polarity;
      cycles(HALF);
      for (int i = 0; i < bits; i++) begin
         mosi = send[len-1-i];
         if (!latching_edge) begin
            cycles(HALF);
            got = {got[30:0], miso};
            sclk = ~sclk;
            last_sample_cycle = cycle;
            cycles(HALF);
            sclk = ~sclk;
         end else begin
            sclk = ~sclk;
            cycles(HALF);
            got = {got[30:0], miso};
            sclk = ~sclk;
            last_sample_cycle = cycle;
            cycles(HALF);
         end
      end
      cycles(HALF);
      if (release_ss) begin
         ss = ~ss_polarity;
         cycles(HALF);
      end
   endtask

   task automatic do_frame(input logic cpol, input logic edge_sel, input logic ss_pol,
                           input logic [5:0] len_field, input bit tx_present,
                           input logic [31:0] tx_word, input logic [31:0] send,
                           input int bits, input bit release_ss,
                           output logic [31:0] got, output int n_rx, output logic [31:0] rx_word,
                           output int d_under, output int d_over, output int d_abort,
                           output int d_ready);
      int len, u0, o0, a0, r0;
      len = (len_field == 6'd0) ? 32 : int'(len_field);
      configure(cpol, edge_sel, ss_pol, len_field);
      tx_bus.data  = tx_word;
      tx_bus.valid = tx_present;
      u0 = underrun_seen; o0 = overrun_seen; a0 = aborted_seen; r0 = ready_seen;
      run_frame(send, len, (bits < 0) ? len : bits, release_ss, got);
      tx_bus.valid = 1'b0;
      d_under = underrun_seen - u0;
      d_over  = overrun_seen - o0;
      d_abort = aborted_seen - a0;
      d_ready = ready_seen - r0;
      n_rx    = rx_q.size() - rx_read;
      rx_word = (n_rx > 0) ? rx_q[rx_read] : 32'h0;
      rx_read = rx_q.size();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cycles(5);
      checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso); end
      checks++; if (miso_enable !== 1'b0) begin errors++; $display("FAIL reset_miso_enable got %b want 0", miso_enable); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
      checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted got %b want 0", aborted); end
      checks++; if (rx_bus.valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_bus.valid); end
      checks++; if (rx_bus.data !== 32'h0) begin errors++; $display("FAIL reset_rx_data got %h want 0", rx_bus.data); end
      checks++; if (tx_bus.ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready got %b want 0", tx_bus.ready); end
      reset = 1'b1;
      cycles(5);
   endtask

   task automatic test_basic();
      logic [31:0] got, rx_word;
      int n_rx, du, dov, da, dr;
      do_frame(1'b0, 1'b0, 1'b0, 6'd8, 1'b1, 32'hA5, 32'h3C, -1, 1'b1,
               got, n_rx, rx_word, du, dov, da, dr);
      checks++; if (got !== 32'hA5) begin errors++; $display("FAIL basic_miso got %h want a5", got); end
      checks++; if (n_rx !== 1) begin errors++; $display("FAIL basic_rx_count got %0d want 1", n_rx); end
      checks++; if (rx_word !== 32'h3C) begin errors++; $display("FAIL basic_rx_data got %h want 3c", rx_word); end
      checks++; if (dr !== 1) begin errors++; $display("FAIL basic_tx_ready got %0d want 1", dr); end
      checks++; if (du !== 0) begin errors++; $display("FAIL basic_underrun got %0d want 0", du); end
      checks++; if (valid_rise_cycle - last_sample_cycle !== SYNC + 3) begin
         errors++; $display("FAIL basic_rx_latency got %0d want %0d", valid_rise_cycle - last_sample_cycle, SYNC + 3);
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
   endtask

   task automatic test_mode3_long();
      logic [31:0] got, rx_word;
      int n_rx, du, dov, da, dr;
      do_frame(1'b1, 1'b1, 1'b1, 6'd32, 1'b1, 32'hDEADBEEF, 32'h12345678, -1, 1'b1,
               got, n_rx, rx_word, du, dov, da, dr);
      checks++; if (got !== 32'hDEADBEEF) begin errors++; $display("FAIL mode3_miso got %h want deadbeef", got); end
      checks++; if (n_rx !== 1) begin errors++; $display("FAIL mode3_rx_count got %0d want 1", n_rx); end
      checks++; if (rx_word !== 32'h12345678) begin errors++; $display("FAIL mode3_rx_data got %h want 12345678", rx_word); end
   endtask

   task automatic test_underrun();
      logic [31:0] got, rx_word;
      int n_rx, du, dov, da, dr;
      do_frame(1'b0, 1'b0, 1'b0, 6'd16, 1'b0, 32'h0, 32'hFFFF, -1, 1'b1,
               got, n_rx, rx_word, du, dov, da, dr);
      checks++; if (du !== 1) begin errors++; $display("FAIL underrun_pulse got %0d want 1", du); end
      checks++; if (dr !== 0) begin errors++; $display("FAIL underrun_tx_ready got %0d want 0", dr); end
      checks++; if (got !== 32'h0) begin errors++; $display("FAIL underrun_miso got %h want 0", got); end
      checks++; if (rx_word !== 32'hFFFF) begin errors++; $display("FAIL underrun_rx_data got %h want ffff", rx_word); end
   endtask

   task automatic test_random();
      logic [31:0] got, rx_word, tx_word, send;
      int n_rx, du, dov, da, dr, len;
      logic cpol, edge_sel;
      logic [5:0] len_field;
      bit present;
      for (int k = 0; k < 8; k++) begin
         cpol      = 1'($urandom_range(0, 1));
         edge_sel  = 1'($urandom_range(0, 1));
         len_field = 6'($urandom_range(0, 32));
         present   = ($urandom_range(0, 3) != 0);
         tx_word   = $urandom;
         send      = $urandom;
         len       = (len_field == 6'd0) ? 32 : int'(len_field);
         do_frame(cpol, edge_sel, 1'b0, len_field, present, tx_word, send, -1, 1'b1,
                  got, n_rx, rx_word, du, dov, da, dr);
         checks++; if (n_rx !== 1) begin errors++; $display("FAIL rand%0d_rx_count got %0d want 1", k, n_rx); end
         checks++; if (rx_word !== low_bits(send, len)) begin
            errors++; $display("FAIL rand%0d_rx_data got %h want %h (len %0d)", k, rx_word, low_bits(send, len), len);
         end
         checks++; if (got !== (present ? low_bits(tx_word, len) : 32'h0)) begin
            errors++; $display("FAIL rand%0d_miso got %h want %h (len %0d)", k, got, present ? low_bits(tx_word, len) : 32'h0, len);
         end
         checks++; if (du !== (present ? 0 : 1)) begin
            errors++; $display("FAIL rand%0d_underrun got %0d want %0d", k, du, present ? 0 : 1);
         end
      end
   endtask

   task automatic test_overrun();
      logic [31:0] got, rx_word;
      int n_rx, du, dov, da, dr;
      rx_bus.ready = 1'b0;
      do_frame(1'b0, 1'b0, 1'b0, 6'd8, 1'b1, 32'h0, 32'h11, -1, 1'b1,
               got, n_rx, rx_word, du, dov, da, dr);
      checks++; if (rx_bus.valid !== 1'b1 || rx_bus.data !== 32'h11) begin
         errors++; $display("FAIL overrun_first_pending got valid %b data %h want 1 11", rx_bus.valid, rx_bus.data);
      end
      do_frame(1'b0, 1'b0, 1'b0, 6'd8, 1'b1, 32'h0, 32'h22, -1, 1'b1,
               got, n_rx, rx_word, du, dov, da, dr);
      checks++; if (dov !== 1) begin errors++; $display("FAIL overrun_pulse got %0d want 1", dov); end
      checks++; if (rx_bus.data !== 32'h11) begin errors++; $display("FAIL overrun_data_held got %h want 11", rx_bus.data); end
      checks++; if (n_rx !== 0) begin errors++; $display("FAIL overrun_no_delivery got %0d want 0", n_rx); end
      rx_bus.ready = 1'b1;
      cycles(4);
      n_rx = rx_q.size() - rx_read;
      rx_word = (n_rx > 0) ? rx_q[rx_read] : 32'h0;
      rx_read = rx_q.size();
      checks++; if (n_rx !== 1) begin errors++; $display("FAIL overrun_release_count got %0d want 1", n_rx); end
      checks++; if (rx_word !== 32'h11) begin errors++; $display("FAIL overrun_release_data got %h want 11", rx_word); end
   endtask

   task automatic test_abort();
      logic [31:0] got, rx_word;
      int n_rx, du, dov, da, dr;
      do_frame(1'b0, 1'b0, 1'b0, 6'd8, 1'b1, 32'h5, 32'hB7, 5, 1'b1,
               got, n_rx, rx_word, du, dov, da, dr);
      checks++; if (da !== 1) begin errors++; $display("FAIL abort_pulse got %0d want 1", da); end
      checks++; if (n_rx !== 0) begin errors++; $display("FAIL abort_no_rx got %0d want 0", n_rx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
      do_frame(1'b0, 1'b0, 1'b0, 6'd8, 1'b1, 32'h7E, 32'h81, -1, 1'b1,
               got, n_rx, rx_word, du, dov, da, dr);
      checks++; if (rx_word !== 32'h81 || n_rx !== 1) begin
         errors++; $display("FAIL abort_next_rx got %h count %0d want 81 count 1", rx_word, n_rx);
      end
      checks++; if (da !== 0) begin errors++; $display("FAIL abort_next_pulse got %0d want 0", da); end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] got, rx_word;
      int n_rx, du, dov, da, dr, a0, u0;
      do_frame(1'b0, 1'b0, 1'b0, 6'd8, 1'b1, 32'h96, 32'hF0, 3, 1'b0,
               got, n_rx, rx_word, du, dov, da, dr);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before got %b want 1", busy); end
      reset = 1'b0;
      cycles(3);
      checks++; if (busy !== 1'b0 || miso_enable !== 1'b0) begin
         errors++; $display("FAIL midreset_busy got %b enable %b want 0 0", busy, miso_enable);
      end
      checks++; if (miso !== 1'b0) begin errors++; $display("FAIL midreset_miso got %b want 0", miso); end
      checks++; if (rx_bus.valid !== 1'b0 || rx_bus.data !== 32'h0) begin
         errors++; $display("FAIL midreset_rx got valid %b data %h want 0 0", rx_bus.valid, rx_bus.data);
      end
      a0 = aborted_seen; u0 = underrun_seen;
      reset = 1'b1;
      cycles(12);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_no_restart got %b want 0", busy); end
      checks++; if (aborted_seen - a0 !== 0 || underrun_seen - u0 !== 0) begin
         errors++; $display("FAIL midreset_pulses got abort %0d underrun %0d want 0 0", aborted_seen - a0, underrun_seen - u0);
      end
      do_frame(1'b0, 1'b0, 1'b0, 6'd8, 1'b1, 32'hC3, 32'h5A, -1, 1'b1,
               got, n_rx, rx_word, du, dov, da, dr);
      checks++; if (rx_word !== 32'h5A || n_rx !== 1) begin
         errors++; $display("FAIL midreset_next_rx got %h count %0d want 5a count 1", rx_word, n_rx);
      end
      checks++; if (got !== 32'hC3) begin errors++; $display("FAIL midreset_next_miso got %h want c3", got); end
   endtask

   initial begin
      tx_bus.data  = '0;
      tx_bus.valid = 1'b0;
      tx_bus.last  = 1'b1;
      rx_bus.ready = 1'b1;
      test_reset();
      test_basic();
      test_mode3_long();
      test_underrun();
      test_random();
      test_overrun();
      test_abort();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
